// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// Each bit lasts the prescale value latched when the frame is accepted, so
// later changes to the configuration inputs do not disturb a frame in flight.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned EDGE_W = 6;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [EDGE_W-1:0]     prescale_q;

    logic [EDGE_W-1:0]     edge_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_d;

    logic                  tx_d;
    logic                  busy_d;

    logic                  accept;
    logic [EDGE_W-1:0]     period_last;
    logic                  bit_end;
    logic                  last_data_bit;
    logic [IDX_W-1:0]      data_idx;

    // A latched prescale of zero behaves like one cycle per bit.
    assign accept        = (state_q == IDLE) && data_valid;
    assign period_last   = (prescale_q == '0) ? '0 : prescale_q - EDGE_W'(1);
    assign bit_end       = (edge_cnt_q == period_last);
    assign last_data_bit = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state advances only at the end of a bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && last_data_bit) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: next line level and busy, derived from the upcoming state so they can be registered.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
        busy_d    = (state_d != IDLE);
        data_idx  = '0;

        if (state_d != DATA) begin
            bit_cnt_d = '0;
        end else if ((state_q == DATA) && bit_end) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end

        data_idx = IDX_W'(bit_cnt_d);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[data_idx];
            PARITY:  tx_d = (^data_q) ^ par_typ_q;
            default: tx_d = 1'b1;
        endcase
    end

    // Registered serial line and busy flag; reset forces the line idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            tx_out <= tx_d;
            busy   <= busy_d;
        end
    end

    // Frame registers captured on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
        end else if (accept) begin
            data_q     <= p_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            prescale_q <= prescale;
        end
    end

    // Edge counter: restarts at every bit boundary and stays cleared while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
        end else if ((state_q == IDLE) || bit_end) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
        end
    end

    // Data bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with an expected-bit scoreboard queue.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd0;
    logic       tx_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Scoreboard push: the line levels a correct UART frame must show.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
    endtask

    // Pop each expected level and hold it against the line for p cycles; optional mid-frame disturbance.
    task automatic drain(input int p, input int disturb_at);
        int cyc;
        bit e;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (p) begin
                chk("tx_bit", tx_out, e);
                chk("busy_frame", busy, 1'b1);
                if (disturb_at >= 0 && cyc == disturb_at) begin
                    prescale   = 6'd16;
                    par_en     = ~par_en;
                    par_typ    = ~par_typ;
                    p_data     = 8'hFF;
                    data_valid = 1'b1;
                end else if (disturb_at >= 0 && cyc == disturb_at + 1) begin
                    data_valid = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end
        end
        chk("tx_idle_after", tx_out, 1'b1);
        chk("busy_idle_after", busy, 1'b0);
    endtask

    // Called at a negedge with the DUT idle: present a frame, expect accept at the next posedge.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input bit hold, input int disturb_at);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        push_frame(d, pe, pt);
        @(posedge clk);
        @(negedge clk);
        if (!hold) data_valid = 1'b0;
        drain((ps == 6'd0) ? 1 : int'(ps), disturb_at);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            chk("idle_tx", tx_out, 1'b1);
            chk("idle_busy", busy, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset held with a pending request: line must stay idle.
        rst        = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'hA5;
        prescale   = 6'd8;
        repeat (2) @(negedge clk);
        repeat (6) begin
            chk("rst_tx", tx_out, 1'b1);
            chk("rst_busy", busy, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;

        // First accept right after release.
        run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, -1);

        // Parity frames at P=4.
        run_frame(8'h01, 1'b1, 1'b0, 6'd4, 1'b0, -1);
        run_frame(8'h01, 1'b1, 1'b1, 6'd4, 1'b0, -1);
        run_frame(8'h03, 1'b1, 1'b0, 6'd4, 1'b0, -1);

        // Config changes and a dropped request mid-frame.
        run_frame(8'hC7, 1'b1, 1'b0, 6'd8, 1'b0, 20);
        check_idle(20);

        // Back-to-back with data_valid held high.
        run_frame(8'h11, 1'b0, 1'b0, 6'd16, 1'b1, -1);
        run_frame(8'h22, 1'b0, 1'b0, 6'd16, 1'b0, -1);

        // Reset in the middle of data bit 3.
        p_data     = 8'h52;
        par_en     = 1'b0;
        prescale   = 6'd4;
        data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_bit3_tx", tx_out, 1'b0);
        chk("mid_bit3_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_tx", tx_out, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        chk("held_rst_tx", tx_out, 1'b1);
        chk("held_rst_busy", busy, 1'b0);
        rst = 1'b1;
        check_idle(2);

        // Prescale zero means one cycle per bit.
        run_frame(8'h5A, 1'b0, 1'b0, 6'd0, 1'b0, -1);
        check_idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
